dmem_responder: RTL

Synthesizable responder for the CPU data-memory port (d_mem_addr/d_mem_wdata/d_mem_wen/d_mem_rdata), replacing the behavioural RAM model in CPU test benches and FPGA builds. It provides a byte-lane-writable word RAM with combinational read and a small MMIO window. The window holds a sticky TOHOST completion register, a free-running cycle counter and a trace-drop counter. Every store is also queued into a write-trace FIFO drained over a valid/ready stream for logging.

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory port responder.
//   Word RAM with byte-lane writes and combinational read, a small MMIO window
//   (TOHOST completion register, cycle counter, trace-drop counter) and a
//   write-trace FIFO drained over a valid/ready stream.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   d_mem_addr        CPU data byte address
//   d_mem_wdata       lane-aligned store data
//   d_mem_wen         byte-lane write enables (0 = read/idle)
//   d_mem_rdata       combinational read data
//   trace_valid/ready head-of-FIFO handshake
//   trace_addr/data/wen head entry fields (0 while trace_valid is low)
//   trace_drop_cnt    stores lost to a full FIFO, saturating
//   done, done_code   sticky completion flag and value written to TOHOST
//   cycle_cnt         cycles since reset, frozen once done is set
module dmem_responder #(
  parameter int unsigned MEM_SIZE_WORDS = 1024,
  parameter int unsigned TRACE_DEPTH    = 8,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_wen,
  output logic [15:0] trace_drop_cnt,
  output logic        done,
  output logic [31:0] done_code,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned AW = $clog2(4 * MEM_SIZE_WORDS);
  localparam int unsigned PW = $clog2(TRACE_DEPTH);
  localparam logic [31:0] RamBytes = 32'(4 * MEM_SIZE_WORDS);
  localparam logic [PW:0] FifoFull = (PW + 1)'(TRACE_DEPTH);

  // Address decode
  logic          ram_hit;
  logic          mmio_hit;
  logic [1:0]    mmio_off;
  logic [AW-3:0] word_idx;

  assign ram_hit  = d_mem_addr < RamBytes;
  assign mmio_hit = d_mem_addr[31:4] == MMIO_BASE[31:4];
  assign mmio_off = d_mem_addr[3:2];
  assign word_idx = d_mem_addr[AW-1:2];

  logic [31:0] mem_q [MEM_SIZE_WORDS];

  logic        done_q;
  logic [31:0] done_code_q;
  logic [31:0] cycle_cnt_q;
  logic [15:0] drop_cnt_q;

  // Read mux
  always_comb begin
    d_mem_rdata = 32'hDEAD_BEEF;
    if (ram_hit) begin
      d_mem_rdata = mem_q[word_idx];
    end else if (mmio_hit) begin
      unique case (mmio_off)
        2'd0:    d_mem_rdata = done_code_q;
        2'd1:    d_mem_rdata = cycle_cnt_q;
        2'd2:    d_mem_rdata = {16'h0000, drop_cnt_q};
        default: d_mem_rdata = 32'h0000_0000;
      endcase
    end
  end

  // RAM contents are never cleared; rst only blocks stores while it is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (d_mem_wen[b]) begin
          mem_q[word_idx][8*b +: 8] <= d_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Completion and counters
  logic tohost_wr;
  assign tohost_wr = mmio_hit && (mmio_off == 2'd0) && (d_mem_wen == 4'hF) && !done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      done_code_q <= 32'h0;
      cycle_cnt_q <= 32'h0;
    end else begin
      // The edge that sets done still counts, since done_q is still 0 here.
      if (!done_q) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (tohost_wr) begin
        done_q      <= 1'b1;
        done_code_q <= d_mem_wdata;
      end
    end
  end

  // Trace FIFO
  logic [31:0]   fifo_addr_q [TRACE_DEPTH];
  logic [31:0]   fifo_data_q [TRACE_DEPTH];
  logic [3:0]    fifo_wen_q  [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  logic push_req, fifo_full, pop, push, drop;

  assign push_req  = d_mem_wen != 4'h0;
  assign fifo_full = count_q == FifoFull;
  assign pop       = (count_q != '0) && trace_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push      = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= d_mem_addr;
      fifo_data_q[wr_ptr_q] <= d_mem_wdata;
      fifo_wen_q[wr_ptr_q]  <= d_mem_wen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= 16'h0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    trace_valid = count_q != '0;
    trace_addr  = 32'h0;
    trace_data  = 32'h0;
    trace_wen   = 4'h0;
    if (trace_valid) begin
      trace_addr = fifo_addr_q[rd_ptr_q];
      trace_data = fifo_data_q[rd_ptr_q];
      trace_wen  = fifo_wen_q[rd_ptr_q];
    end
  end

  assign trace_drop_cnt = drop_cnt_q;
  assign done           = done_q;
  assign done_code      = done_code_q;
  assign cycle_cnt      = cycle_cnt_q;

endmodule
